// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared state enum, select-width helper and default sizes for rr_mux_arbiter
package rr_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int DEF_N = 4;
  localparam int DEF_W = 8;
  localparam int DEF_TIMEOUT = 16;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mux_nx1.sv
// mux_nx1: parameterised N:1 mux of W-bit lanes; d packs lane i at [i*W +: W], sel picks lane, y is the chosen lane
module mux_nx1
  import rr_arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W + 1
) (
  input  logic [N*W-1:0]      d,
  input  logic [clog2(N)-1:0] sel,
  output logic [W-1:0]        y
);
  assign y = d[sel*W +: W];
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin packet arbiter driving an N:1 mux select onto one shared channel
// Ports: clk, rst (sync, active-high); req/data_in/last_in/in_ready per requester;
// out_valid/out_data/out_last/out_ready shared channel; grant (one-hot), sel (index), err (timeout pulse).
// Optional grant timeout compiled in with RR_ARB_TIMEOUT_EN; otherwise err is 0 and grants never expire.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N*W-1:0]      data_in,
  input  logic [N-1:0]        last_in,
  output logic [N-1:0]        in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [N-1:0]        grant,
  output logic [clog2(N)-1:0] sel,
  output logic                err
);
  localparam int SW = clog2(N);
  state_t state, state_n;
  logic [N-1:0] grant_n;
  logic [SW-1:0] sel_n, ptr, ptr_n;
  logic [N*(W+1)-1:0] bus;
  logic [W:0] m;
  logic busy, xfer_last, tmo;
  // Scan downward so the last hit written is the nearest set bit after p
  function automatic logic [SW-1:0] next_idx(input logic [N-1:0] r, input logic [SW-1:0] p);
    logic [SW-1:0] j;
    next_idx = p;
    for (int k = N; k >= 1; k--) begin
      j = SW'((int'(p) + k) % N);
      if (r[j]) next_idx = j;
    end
  endfunction
  for (genvar i = 0; i < N; i++) begin : g_bus
    assign bus[i*(W+1) +: W+1] = {last_in[i], data_in[i*W +: W]};
  end
  mux_nx1 #(.N(N), .W(W+1)) u_mux (.d(bus), .sel(sel), .y(m));
  assign busy = state == BUSY;
  assign out_valid = busy & req[sel];
  assign out_data = busy ? m[W-1:0] : '0;
  assign out_last = busy & m[W];
  // Driven from the registered grant so out_ready never reaches out_valid
  assign in_ready = (busy & out_ready) ? grant : '0;
  assign xfer_last = out_valid & out_ready & out_last;
`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic err_q;
  assign tmo = busy & (cnt == CW'(TIMEOUT - 1)) & ~xfer_last;
  assign err = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= busy ? cnt + 1'b1 : '0;
      err_q <= tmo;
    end
  end
`else
  // TIMEOUT is only meaningful when the timeout is compiled in
  assign tmo = 1'b0 & (TIMEOUT > 0);
  assign err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n = sel;
    ptr_n = ptr;
    if (!busy && |req) begin
      sel_n = next_idx(req, ptr);
      grant_n = N'(1) << sel_n;
      state_n = BUSY;
    end else if (busy && (xfer_last || tmo)) begin
      state_n = IDLE;
      grant_n = '0;
      ptr_n = sel;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      sel <= '0;
      ptr <= SW'(N - 1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      sel <= sel_n;
      ptr <= ptr_n;
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, last_in, in_ready, grant;
  logic [N*W-1:0] data_in;
  logic out_valid, out_last, out_ready, err;
  logic [W-1:0] out_data;
  logic [1:0] sel;
  int tests = 0;
  int fails = 0;
  int e [7] = '{2, 0, 4, 0, 2, 0, 4};
  always #5 clk = ~clk;
  rr_mux_arbiter #(.N(N), .W(W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .last_in(last_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .grant(grant), .sel(sel), .err(err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_data(input logic [3:0] b);
    for (int i = 0; i < N; i++) data_in[i*W +: W] = {4'(i + 1), b};
  endtask
  function automatic logic [7:0] beat(input int g, input int b);
    return {4'(g + 1), 4'(b)};
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    last_in = '0;
    out_ready = 1'b0;
    set_data(4'd0);
    step();
    step();
    rst = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_sel", sel, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("idle_grant", grant, 0);
      check("idle_valid", out_valid, 0);
      check("idle_ready", in_ready, 0);
      check("idle_err", err, 0);
    end
    do_reset();
    req = 4'b0110;
    last_in = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      check("rr2_grant", grant, e[c]);
      check("rr2_ready", in_ready, e[c]);
      check("rr2_valid", out_valid, e[c] != 0);
    end
    req = 4'b0100;
    step();
    check("rr2_end", grant, 0);
    req = '0;
    do_reset();
    req = 4'b1111;
    out_ready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < 3; b++) begin
        step();
        set_data(4'(b));
        last_in = (b == 2) ? 4'b1111 : 4'b0000;
        #1;
        check("pkt_grant", grant, 1 << (p % 4));
        check("pkt_ready", in_ready, 1 << (p % 4));
        check("pkt_data", out_data, beat(p % 4, b));
        check("pkt_last", out_last, b == 2);
      end
      step();
      last_in = '0;
      if (p == 4) req = '0;
      check("pkt_gap", grant, 0);
      check("pkt_gap_valid", out_valid, 0);
    end
    do_reset();
    req = 4'b0100;
    step();
    for (int c = 0; c < 4; c++) begin
      check("stall_grant", grant, 4'b0100);
      check("stall_valid", out_valid, 1);
      check("stall_ready", in_ready, 0);
      check("stall_data", out_data, beat(2, 0));
      step();
    end
    out_ready = 1'b1;
    #1;
    check("stall_go_ready", in_ready, 4'b0100);
    check("stall_go_data", out_data, beat(2, 0));
    step();
    set_data(4'd1);
    req = '0;
    #1;
    for (int c = 0; c < 2; c++) begin
      check("drop_valid", out_valid, 0);
      check("drop_grant", grant, 4'b0100);
      step();
    end
    req = 4'b0100;
    last_in = 4'b0100;
    #1;
    check("drop_resume_valid", out_valid, 1);
    check("drop_resume_data", out_data, beat(2, 1));
    check("drop_resume_last", out_last, 1);
    step();
    check("drop_release", grant, 0);
    req = '0;
    last_in = '0;
    do_reset();
    req = 4'b0010;
    last_in = 4'b1111;
    out_ready = 1'b1;
    step();
    check("pre_grant", grant, 4'b0010);
    step();
    req = 4'b0100;
    last_in = '0;
    step();
    check("abort_grant", grant, 4'b0100);
    step();
    rst = 1'b1;
    step();
    check("abort_rst_grant", grant, 0);
    check("abort_rst_ready", in_ready, 0);
    check("abort_rst_valid", out_valid, 0);
    rst = 1'b0;
    req = 4'b1111;
    last_in = 4'b1111;
    step();
    check("abort_ptr", grant, 4'b0001);
    step();
    req = 4'b1000;
    step();
    check("abort_req3", grant, 4'b1000);
    step();
    req = '0;
`ifdef RR_ARB_TIMEOUT_EN
    do_reset();
    req = 4'b0001;
    out_ready = 1'b1;
    step();
    for (int c = 0; c < 16; c++) begin
      check("tmo_hold", grant, 4'b0001);
      check("tmo_err_lo", err, 0);
      step();
    end
    check("tmo_release", grant, 0);
    check("tmo_err", err, 1);
    req = 4'b0011;
    step();
    check("tmo_next", grant, 4'b0010);
    check("tmo_err_once", err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one W-bit output channel between N requesters by driving the select of an N:1 mux. Each requester presents a packet of one or more beats. A grant is held until the packet's last beat is accepted downstream, then rotated. This block sits in front of any shared datapath built from the team's mux primitives and is the only thing allowed to drive that mux select.

## Interface
- N, default 4: number of requesters (2..16)
- W, default 8: data width per beat
- TIMEOUT, default 16: maximum cycles a grant may be held; used only when RR_ARB_TIMEOUT_EN is defined
- clk  input  1  clock; all logic rising-edge
- rst  input  1  reset; synchronous and active-high
- req  input  N  per-requester valid; bit i means requester i has a beat on offer
- data_in  input  N*W  packed beats; requester i occupies bits [i*W +: W]
- last_in  input  N  per-requester last-beat flag
- in_ready  output  N  per-requester accept; at most one bit set
- out_valid  output  1  beat valid on the shared channel
- out_data  output  W  muxed beat
- out_last  output  1  muxed last flag
- out_ready  input  1  downstream accept
- grant  output  N  one-hot registered grant; all zeros when idle
- sel  output  clog2(N)  registered mux select; its value is the index of the granted requester
- err  output  1  one-cycle timeout pulse; tied to 0 when the macro is absent

## Operation
- The FSM has two states, IDLE and BUSY.
- Reset values:
  - state = IDLE, grant = 0, sel = 0, err = 0
  - rotation pointer ptr = N-1, so requester 0 wins first
  - the combinational outputs are therefore 0 while in IDLE
- IDLE:
  - If req is non-zero, pick the first set bit searching ptr+1, ptr+2, … modulo N.
  - Register that index into sel, set grant to its one-hot value, and go to BUSY.
  - If req is zero, stay in IDLE.
- BUSY with granted index g:
  - out_valid = req[g]
  - out_data = data_in[g]
  - out_last = last_in[g]
  - in_ready[g] = out_ready; all other in_ready bits are 0
  - A beat transfers when out_valid && out_ready.
- Release:
  - A transfer with out_last=1 sends the FSM to IDLE on the next edge.
  - On that edge ptr := g and grant := 0.
- Requester drop: if req[g] deasserts mid-packet, the grant is held and out_valid = 0. There is no release without a last beat (except by timeout, when compiled in).
- Data stability: other requesters' req changes never affect an active grant.
- Single requester: that requester wins every arbitration, separated by the mandatory IDLE cycle.
- Reset mid-packet: everything returns to the reset values on the next edge. The in-flight packet is abandoned, and no further in_ready is asserted for it.

## Timing
- Arbitration latency is 1 cycle: req rising at edge k gives grant/sel valid and the first possible transfer in cycle k+1.
- out_valid, out_data and out_last are combinational from req/data_in/last_in through the mux. They are not registered, so there is zero data latency.
- in_ready depends combinationally on out_ready. No path from out_ready to out_valid is allowed.
- Throughput:
  - 1 beat per cycle within a packet
  - 1 dead IDLE cycle between packets
  - Minimum cycles for a P-beat packet are P+1, arbitration included.
- Fairness: with all N requesting continuously, each requester is granted once every N packets.

## Configuration
- RR_ARB_TIMEOUT_EN defined:
  - A cycle counter clears on entry to BUSY and increments every BUSY cycle.
  - When the count reaches TIMEOUT-1 without a last-beat transfer, the FSM goes to IDLE on the next edge with ptr := g.
  - err pulses high for exactly that one cycle, which is the first IDLE cycle.
  - A last-beat transfer in the same cycle as the timeout counts as a normal release, with err = 0.
- Not defined: no counter, err is constant 0, and the grant is held indefinitely.

## Structure
- Shared package rr_arb_pkg holds:
  - the state enum (IDLE, BUSY)
  - a sel-width function clog2
  - the default N, W and TIMEOUT constants
- Sub-module mux_nx1 is a parameterised N:1 mux of W+1 bits, carrying {last,data}, selected by sel. It extends the existing mux2x1 style primitive and is instantiated once.
- The arbiter's next-index search is a plain function, not a module.

## Test plan
- Reset, then req=0000: grant=0000, out_valid=0, in_ready=0000 and err=0 held for 5 cycles.
- req=0110, all 1-beat packets, out_ready=1: grants are 0010 and 0100, each lasting one cycle with one IDLE cycle between, with the order repeating 1,2,1,2.
- req=1111 continuously, 3-beat packets with last on beat 3: grant order is 0,1,2,3,0, and each grant spans exactly 3 transfer cycles.
- Granted requester 2, out_ready=0 for 4 cycles then 1: grant stays 0100, out_data stays data_in[2] and no beat is lost. Separately, req[2] dropping for 2 cycles mid-packet gives out_valid=0 with grant held.
- rst asserted in the 2nd beat of a 3-beat packet: the next edge gives grant=0000 and ptr=N-1, and a subsequent req=1000 is granted 1000.
- With RR_ARB_TIMEOUT_EN and TIMEOUT=16: requester 0 holds with last never set. The grant is released after 16 BUSY cycles, err=1 for one cycle, and the next req=0011 is granted 0010.
